// File: rtl/soc_top.sv
`default_nettype none
// ============================================================================
//  Module      : soc_top
//  Description : UART-controlled GPIO SoC. An 8N1 receiver feeds a byte
//                command parser that writes the 32-bit GPIO output and
//                output-enable registers and reads back the GPIO inputs.
//                A banner byte is transmitted once after every reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_top #(
   parameter int         CLKS_PER_BIT = 16,
   parameter logic [7:0] BANNER       = 8'h5A
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        uart_rx_i,
   output logic        uart_tx_o,
   output logic        uart_tx_en_o,
   input  logic [31:0] gpio_i,
   output logic [31:0] gpio_o,
   output logic [31:0] gpio_en_o
);

   localparam int            CW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   // Receiver states
   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   // Command parser states
   localparam logic [1:0] ST_BANNER  = 2'd0;
   localparam logic [1:0] ST_IDLE    = 2'd1;
   localparam logic [1:0] ST_PAYLOAD = 2'd2;
   localparam logic [1:0] ST_REPLY   = 2'd3;

   // Synchronizers
   logic        rx_meta_q, rx_sync_q;
   logic [31:0] gpio_meta_q, gpio_sync_q;

   // Receiver
   logic [1:0]    rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          rx_armed_q, rx_armed_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_ferr_q, rx_ferr_d;

   // Transmitter
   logic          tx_busy_q, tx_busy_d;
   logic          tx_line_q, tx_line_d;
   logic [8:0]    tx_shift_q, tx_shift_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]    tx_bit_q, tx_bit_d;
   logic          tx_en_q;
   logic          tx_req;
   logic [7:0]    tx_byte;
   logic          tx_ready;

   // Parser and register file
   logic [1:0]  st_q, st_d;
   logic [31:0] reply_q, reply_d;
   logic [2:0]  reply_cnt_q, reply_cnt_d;
   logic [31:0] pay_q, pay_d;
   logic [1:0]  pay_cnt_q, pay_cnt_d;
   logic        load_pend_q, load_pend_d;
   logic        tgt_en_q, tgt_en_d;
   logic [31:0] gpio_out_q, gpio_out_d;
   logic [31:0] gpio_oe_q, gpio_oe_d;

   assign tx_ready = ~tx_busy_q;

   // RX bit engine: arm on idle-high line, re-check start at half bit, sample at bit centres
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_armed_d = rx_armed_q;
      rx_valid_d = 1'b0;
      rx_ferr_d  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            if (rx_sync_q) begin
               rx_armed_d = 1'b1;
            end else if (rx_armed_q) begin
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt_q == C_HALF_LAST) begin
               rx_cnt_d   = '0;
               // A high line at mid start bit is a glitch, not a frame
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == C_BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == C_BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               if (rx_sync_q) begin
                  rx_valid_d = 1'b1;
               end else begin
                  // Disarm so a held-low line yields only one error
                  rx_ferr_d  = 1'b1;
                  rx_armed_d = 1'b0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // TX bit engine: start bit on the cycle after accept, then 8 data bits and stop
   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_line_d  = tx_line_q;
      tx_shift_d = tx_shift_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      if (!tx_busy_q) begin
         if (tx_req) begin
            tx_busy_d  = 1'b1;
            tx_line_d  = 1'b0;
            tx_shift_d = {1'b1, tx_byte};
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
         end
      end else if (tx_cnt_q == C_BIT_LAST) begin
         tx_cnt_d = '0;
         if (tx_bit_q == 4'd9) begin
            tx_busy_d = 1'b0;
            tx_line_d = 1'b1;
         end else begin
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
         end
      end else begin
         tx_cnt_d = tx_cnt_q + 1'b1;
      end
   end

   // Command parser: decode opcodes, gather payload, stream replies to TX
   always_comb begin
      st_d        = st_q;
      reply_d     = reply_q;
      reply_cnt_d = reply_cnt_q;
      pay_d       = pay_q;
      pay_cnt_d   = pay_cnt_q;
      load_pend_d = load_pend_q;
      tgt_en_d    = tgt_en_q;
      gpio_out_d  = gpio_out_q;
      gpio_oe_d   = gpio_oe_q;
      tx_req      = 1'b0;
      tx_byte     = reply_q[31:24];
      case (st_q)
         ST_BANNER: begin
            tx_req  = 1'b1;
            tx_byte = BANNER;
            if (tx_ready) begin
               st_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (rx_valid_q) begin
               case (rx_shift_q)
                  8'h57: begin
                     st_d      = ST_PAYLOAD;
                     tgt_en_d  = 1'b0;
                     pay_cnt_d = 2'd0;
                  end
                  8'h45: begin
                     st_d      = ST_PAYLOAD;
                     tgt_en_d  = 1'b1;
                     pay_cnt_d = 2'd0;
                  end
                  8'h52: begin
                     st_d        = ST_REPLY;
                     reply_d     = gpio_sync_q;
                     reply_cnt_d = 3'd4;
                  end
                  default: begin
                     st_d        = ST_REPLY;
                     reply_d     = {8'h3F, 24'h0};
                     reply_cnt_d = 3'd1;
                  end
               endcase
            end
         end
         ST_PAYLOAD: begin
            if (load_pend_q) begin
               // Whole word lands in one cycle so the pins never see a partial value
               load_pend_d = 1'b0;
               if (tgt_en_q) begin
                  gpio_oe_d = pay_q;
               end else begin
                  gpio_out_d = pay_q;
               end
               st_d        = ST_REPLY;
               reply_d     = {8'h4B, 24'h0};
               reply_cnt_d = 3'd1;
            end else if (rx_ferr_q) begin
               st_d      = ST_IDLE;
               pay_cnt_d = 2'd0;
            end else if (rx_valid_q) begin
               pay_d     = {pay_q[23:0], rx_shift_q};
               pay_cnt_d = pay_cnt_q + 2'd1;
               if (pay_cnt_q == 2'd3) begin
                  load_pend_d = 1'b1;
               end
            end
         end
         ST_REPLY: begin
            tx_req = 1'b1;
            if (tx_ready) begin
               reply_d     = {reply_q[23:0], 8'h00};
               reply_cnt_d = reply_cnt_q - 3'd1;
               if (reply_cnt_q == 3'd1) begin
                  st_d = ST_IDLE;
               end
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   // All state, asynchronously reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         gpio_meta_q <= '0;
         gpio_sync_q <= '0;
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_shift_q  <= '0;
         rx_armed_q  <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_ferr_q   <= 1'b0;
         tx_busy_q   <= 1'b0;
         tx_line_q   <= 1'b1;
         tx_shift_q  <= '1;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         tx_en_q     <= 1'b0;
         st_q        <= ST_BANNER;
         reply_q     <= '0;
         reply_cnt_q <= '0;
         pay_q       <= '0;
         pay_cnt_q   <= '0;
         load_pend_q <= 1'b0;
         tgt_en_q    <= 1'b0;
         gpio_out_q  <= '0;
         gpio_oe_q   <= '0;
      end else begin
         rx_meta_q   <= uart_rx_i;
         rx_sync_q   <= rx_meta_q;
         gpio_meta_q <= gpio_i;
         gpio_sync_q <= gpio_meta_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         rx_armed_q  <= rx_armed_d;
         rx_valid_q  <= rx_valid_d;
         rx_ferr_q   <= rx_ferr_d;
         tx_busy_q   <= tx_busy_d;
         tx_line_q   <= tx_line_d;
         tx_shift_q  <= tx_shift_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_en_q     <= 1'b1;
         st_q        <= st_d;
         reply_q     <= reply_d;
         reply_cnt_q <= reply_cnt_d;
         pay_q       <= pay_d;
         pay_cnt_q   <= pay_cnt_d;
         load_pend_q <= load_pend_d;
         tgt_en_q    <= tgt_en_d;
         gpio_out_q  <= gpio_out_d;
         gpio_oe_q   <= gpio_oe_d;
      end
   end

   assign uart_tx_o    = tx_line_q;
   assign uart_tx_en_o = tx_en_q;
   assign gpio_o       = gpio_out_q;
   assign gpio_en_o    = gpio_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_top
//  Description : Directed self-checking bench for soc_top. A host model
//                drives 8N1 frames into the RX pin; a line decoder collects
//                bytes from the TX pin for comparison against fixed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_top;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx;
   logic        tx;
   logic        tx_en;
   logic [31:0] gi;
   logic [31:0] go;
   logic [31:0] ge;

   int errors = 0;
   int checks = 0;

   logic [7:0] txq[$];
   logic       stopq[$];

   always #5 clk = ~clk;

   soc_top #(
      .CLKS_PER_BIT(CPB),
      .BANNER      (8'h5A)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .uart_rx_i   (rx),
      .uart_tx_o   (tx),
      .uart_tx_en_o(tx_en),
      .gpio_i      (gi),
      .gpio_o      (go),
      .gpio_en_o   (ge)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Decode TX frames by counting clocks from the start edge to bit centres
   initial begin : tx_mon
      logic [7:0] b;
      forever begin
         @(negedge tx);
         if (rst_n !== 1'b1) continue;
         repeat (CPB / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
         end
         repeat (CPB) @(negedge clk);
         txq.push_back(b);
         stopq.push_back(tx);
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Wait (bounded) for n bytes, compare them MSB-first against exp, clear the queue
   task automatic expect_reply(input string tag, input int n, input logic [31:0] exp);
      int t;
      t = 0;
      while (txq.size() < n && t < 60 * CPB) begin
         @(negedge clk);
         t++;
      end
      repeat (2 * CPB) @(negedge clk);
      check_eq({tag, " count"}, txq.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < txq.size()) begin
            check_eq({tag, " byte"}, {24'h0, txq[i]}, {24'h0, exp[8*(n-1-i) +: 8]});
            check_eq({tag, " stop"}, {31'h0, stopq[i]}, 32'h1);
         end
      end
      txq.delete();
      stopq.delete();
   endtask

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin : main
      rx = 1'b1;
      gi = 32'h0;
      repeat (5) @(negedge clk);
      check_eq("rst tx", {31'h0, tx}, 32'h1);
      check_eq("rst tx_en", {31'h0, tx_en}, 32'h0);
      check_eq("rst gpio_o", go, 32'h0);
      check_eq("rst gpio_en", ge, 32'h0);
      txq.delete();
      stopq.delete();

      // Release: tx_en and the banner start bit appear after the first edge
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("tx_en after rst", {31'h0, tx_en}, 32'h1);
      check_eq("banner start", {31'h0, tx}, 32'h0);
      expect_reply("banner", 1, 32'h5A);
      check_eq("tx idle", {31'h0, tx}, 32'h1);

      // Write gpio_o
      send_byte(8'h57); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      check_eq("wr gpio_o", go, 32'hDEADBEEF);
      check_eq("wr gpio_en keep", ge, 32'h0);
      expect_reply("wr ack", 1, 32'h4B);

      // Write gpio_en_o
      send_byte(8'h45); send_byte(8'h00); send_byte(8'h00); send_byte(8'hFF); send_byte(8'hFF);
      check_eq("en gpio_en", ge, 32'h0000FFFF);
      check_eq("en gpio_o keep", go, 32'hDEADBEEF);
      expect_reply("en ack", 1, 32'h4B);

      // Read gpio_i
      gi = 32'h12345678;
      repeat (4) @(negedge clk);
      send_byte(8'h52);
      expect_reply("read", 4, 32'h12345678);

      // Unknown opcode
      send_byte(8'h41);
      expect_reply("unknown", 1, 32'h3F);

      // Partial command killed by a framing error
      send_byte(8'h57); send_byte(8'h11); send_byte(8'h22);
      send_byte(8'h33, 1'b0);
      repeat (4 * CPB) @(negedge clk);
      check_eq("ferr gpio_o", go, 32'hDEADBEEF);
      expect_reply("ferr no reply", 0, 32'h0);
      send_byte(8'h57); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      check_eq("post ferr gpio_o", go, 32'hAABBCCDD);
      expect_reply("post ferr ack", 1, 32'h4B);

      // Reset in the middle of a payload
      send_byte(8'h57); send_byte(8'h01);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("mid rst gpio_o", go, 32'h0);
      check_eq("mid rst gpio_en", ge, 32'h0);
      check_eq("mid rst tx_en", {31'h0, tx_en}, 32'h0);
      txq.delete();
      stopq.delete();
      rst_n = 1'b1;
      expect_reply("rebanner", 1, 32'h5A);

      // Break: line held low across reset release
      rst_n = 1'b0;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      txq.delete();
      stopq.delete();
      rst_n = 1'b1;
      repeat (40 * CPB) @(negedge clk);
      expect_reply("break", 1, 32'h5A);
      check_eq("break gpio_o", go, 32'h0);
      check_eq("break gpio_en", ge, 32'h0);

      // Line recovers and commands work again
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      send_byte(8'h57); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      check_eq("recover gpio_o", go, 32'h01020304);
      expect_reply("recover ack", 1, 32'h4B);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
